// File: rtl/mat_mac_stream.sv
// mat_mac_stream: streaming signed fractional dot-product engine with operand correction, product rounding and saturating accumulation
module mat_mac_stream #(
    parameter int WIDTH_A_80         = 9,
    parameter int WIDTH_B_80         = 8,
    parameter int WIDTH_PROD         = WIDTH_A_80 + WIDTH_B_80,
    parameter int WIDTH_PROD_ROUNDED = 9,
    parameter int WIDTH_SUM          = 11,
    parameter int VEC_LEN            = 4,
    parameter int CNT_W              = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
    input  logic                  clk_80,
    input  logic                  rst_80,
    input  logic                  clr_80,
    input  logic [WIDTH_A_80-1:0] a_80,
    input  logic [WIDTH_B_80-1:0] b_80,
    input  logic                  in_valid_80,
    output logic                  in_ready_80,
    output logic [WIDTH_SUM-1:0]  out_data_80,
    output logic                  out_sat_80,
    output logic                  out_valid_80,
    input  logic                  out_ready_80
);
    localparam int WR = WIDTH_PROD_ROUNDED;
    localparam int D  = WIDTH_PROD - 1 - WR;
    localparam logic [WIDTH_A_80-1:0] A_MIN   = {1'b1, {(WIDTH_A_80-1){1'b0}}};
    localparam logic [WIDTH_B_80-1:0] B_MIN   = {1'b1, {(WIDTH_B_80-1){1'b0}}};
    localparam logic [WR-1:0]         R_MAX   = {1'b0, {(WR-1){1'b1}}};
    localparam logic [WIDTH_SUM-1:0]  SUM_MAX = {1'b0, {(WIDTH_SUM-1){1'b1}}};
    localparam logic [WIDTH_SUM-1:0]  SUM_MIN = {1'b1, {(WIDTH_SUM-1){1'b0}}};
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {S_ACC, S_FLUSH, S_HOLD} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    s1_valid_q, s1_valid_d;
    logic [WR-1:0]           r_q, r_d;
    logic [WIDTH_SUM-1:0]    acc_q, acc_d;
    logic                    sat_q, sat_d;
    logic [WIDTH_SUM-1:0]    out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;
    logic                    out_valid_q, out_valid_d;
    logic                    accept, last, load, release_out;
    logic signed [WIDTH_A_80-1:0] a_c;
    logic signed [WIDTH_B_80-1:0] b_c;
    logic signed [WIDTH_PROD-1:0] p;
    logic [WR-1:0]           p_trunc, r_rnd;
    logic [WIDTH_SUM:0]      sum;
    logic                    ovf;
    logic [WIDTH_SUM-1:0]    sum_sat;
    logic                    unused_p;

    always_ff @(posedge clk_80 or posedge rst_80) begin
        if (rst_80) state_q <= S_ACC;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr_80)                                 state_d = S_ACC;
        else if (state_q == S_ACC && accept && last) state_d = S_FLUSH;
        else if (load)                              state_d = S_HOLD;
        else if (release_out)                       state_d = S_ACC;
    end

    always_comb begin
        in_ready_80 = state_q == S_ACC;
        load        = state_q == S_FLUSH && !s1_valid_q;
        release_out = state_q == S_HOLD && out_ready_80;
    end

    always_comb begin
        accept  = in_valid_80 && in_ready_80 && !clr_80;
        last    = cnt_q == CNT_LAST;
        a_c     = (a_80 == A_MIN) ? a_80 + WIDTH_A_80'(1) : a_80;
        b_c     = (b_80 == B_MIN) ? b_80 + WIDTH_B_80'(1) : b_80;
        p       = WIDTH_PROD'(a_c) * WIDTH_PROD'(b_c);
        p_trunc = p[WIDTH_PROD-2 -: WR];
        // round half up; only the largest positive truncation can overflow
        r_rnd   = (p_trunc == R_MAX && p[D-1]) ? R_MAX : p_trunc + WR'(p[D-1]);
        unused_p = ^{p[WIDTH_PROD-1], p[D-2:0]};
        sum     = {acc_q[WIDTH_SUM-1], acc_q} + {{(WIDTH_SUM+1-WR){r_q[WR-1]}}, r_q};
        ovf     = sum[WIDTH_SUM] ^ sum[WIDTH_SUM-1];
        sum_sat = ovf ? (sum[WIDTH_SUM] ? SUM_MIN : SUM_MAX) : sum[WIDTH_SUM-1:0];
        cnt_d       = clr_80 ? '0 : accept ? (last ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
        s1_valid_d  = accept;
        r_d         = accept ? r_rnd : r_q;
        acc_d       = (clr_80 || release_out) ? '0 : s1_valid_q ? sum_sat : acc_q;
        sat_d       = (clr_80 || release_out) ? 1'b0 : (s1_valid_q && ovf) ? 1'b1 : sat_q;
        out_data_d  = (load && !clr_80) ? acc_q : out_data_q;
        out_sat_d   = (load && !clr_80) ? sat_q : out_sat_q;
        out_valid_d = clr_80 ? 1'b0 : load ? 1'b1 : release_out ? 1'b0 : out_valid_q;
    end

    always_ff @(posedge clk_80 or posedge rst_80) begin
        if (rst_80) begin
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            r_q         <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            r_q         <= r_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data_80  = out_data_q;
    assign out_sat_80   = out_sat_q;
    assign out_valid_80 = out_valid_q;
endmodule

// File: tb/tb_mat_mac_stream.sv
// tb_mat_mac_stream: randomized scoreboard bench with directed corner vectors for mat_mac_stream
module tb_mat_mac_stream;
    logic clk = 0, rst = 1, clr = 0, in_valid = 0, out_ready = 0;
    logic [8:0] a = 0;
    logic [7:0] b = 0;
    logic in_ready, out_sat, out_valid;
    logic [10:0] out_data;
    logic clr8 = 0, iv8 = 0;
    logic [8:0] a8 = 0;
    logic [7:0] b8 = 0;
    logic ir8, os8, ov8;
    logic [10:0] od8;
    int checks = 0, errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;
    bit rand_rdy = 0;
    logic [8:0] va[4];
    logic [7:0] vb[4];

    always #5 clk = ~clk;

    mat_mac_stream dut (
        .clk_80(clk), .rst_80(rst), .clr_80(clr), .a_80(a), .b_80(b),
        .in_valid_80(in_valid), .in_ready_80(in_ready), .out_data_80(out_data),
        .out_sat_80(out_sat), .out_valid_80(out_valid), .out_ready_80(out_ready)
    );

    mat_mac_stream #(.VEC_LEN(8), .CNT_W(3)) u8 (
        .clk_80(clk), .rst_80(rst), .clr_80(clr8), .a_80(a8), .b_80(b8),
        .in_valid_80(iv8), .in_ready_80(ir8), .out_data_80(od8),
        .out_sat_80(os8), .out_valid_80(ov8), .out_ready_80(1'b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: fractional product rounded half up in plain integer arithmetic
    function automatic int rnd_term(input logic [8:0] x, input logic [7:0] y);
        int ai, bi, r;
        ai = $signed(x);
        bi = $signed(y);
        if (ai == -256) ai = -255;
        if (bi == -128) bi = -127;
        r = (ai * bi + 64) >>> 7;
        if (r > 255) r = 255;
        return r;
    endfunction

    function automatic logic [11:0] ref_vec();
        int acc = 0;
        bit s = 0;
        for (int i = 0; i < 4; i++) begin
            acc += rnd_term(va[i], vb[i]);
            if (acc > 1023) begin acc = 1023; s = 1; end
            else if (acc < -1024) begin acc = -1024; s = 1; end
        end
        return {s, 11'(acc)};
    endfunction

    task automatic send_elem(input logic [8:0] ai, input logic [7:0] bi);
        bit got = 0;
        a = ai; b = bi; in_valid = 1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk); got = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic send8(input logic [8:0] ai, input logic [7:0] bi);
        bit got = 0;
        a8 = ai; b8 = bi; iv8 = 1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk); got = ir8;
            @(posedge clk); #1;
        end
        iv8 = 0;
        if (!got) check("accept8_timeout", 0, 1);
    endtask

    task automatic vec8(input logic [8:0] ai, input logic [7:0] bi, input logic [10:0] ed, input logic es);
        repeat (8) send8(ai, bi);
        for (int k = 0; k < 10 && !ov8; k++) @(negedge clk);
        check("v8_valid", ov8, 1);
        check("v8_data", od8, ed);
        check("v8_sat", os8, es);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin @(posedge clk); #1; end
        check("drain", exp_q.size(), 0);
    endtask

    always @(posedge clk) if (rand_rdy) begin #1; out_ready = ($urandom_range(0, 2) != 0); end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("out_data", out_data, mon_e[10:0]);
                check("out_sat", out_sat, mon_e[11]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_valid8", ov8, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // 0.5 x 0.5 four times, result held unacknowledged
        exp_q.push_back({1'b0, 11'h100});
        repeat (4) send_elem(9'h080, 8'h40);
        @(negedge clk); check("lat_e0", out_valid, 0);
        @(negedge clk); check("lat_e1", out_valid, 0);
        @(negedge clk); check("lat_e2", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, 11'h100);
            check("hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1;
        @(posedge clk); #1 out_ready = 0;
        @(negedge clk);
        check("resume_in_ready", in_ready, 1);
        check("resume_out_valid", out_valid, 0);
        @(posedge clk); #1 out_ready = 1;

        // both operands at the illegal most-negative code
        exp_q.push_back({1'b0, 11'h0FD});
        send_elem(9'h100, 8'h80);
        repeat (3) send_elem(9'h000, 8'h00);
        drain();

        // abort after two terms, element presented with clr dropped
        repeat (2) send_elem(9'h080, 8'h40);
        clr = 1; in_valid = 1; a = 9'h0FF; b = 8'h7F;
        @(posedge clk); #1 clr = 0; in_valid = 0;
        exp_q.push_back({1'b0, 11'h100});
        repeat (4) send_elem(9'h080, 8'h40);
        drain();

        // eight-term engine: positive clamp, clean vector, negative clamp
        vec8(9'h0FF, 8'h7F, 11'h3FF, 1'b1);
        vec8(9'h000, 8'h00, 11'h000, 1'b0);
        vec8(9'h101, 8'h7F, 11'h400, 1'b1);

        // reset while flushing must suppress the result
        repeat (4) send_elem(9'h080, 8'h40);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); check("rst_flush_no_valid", out_valid, 0);
        end
        check("rst_flush_in_ready", in_ready, 1);
        @(posedge clk); #1;

        rand_rdy = 1;
        for (int v = 0; v < 1000; v++) begin
            for (int i = 0; i < 4; i++) begin
                int r = $urandom_range(0, 5);
                va[i] = (r == 0) ? 9'h100 : (r == 1) ? 9'h0FF : (r == 2) ? 9'h101 : 9'($urandom);
                r = $urandom_range(0, 5);
                vb[i] = (r == 0) ? 8'h80 : (r == 1) ? 8'h7F : (r == 2) ? 8'h81 : 8'($urandom);
            end
            exp_q.push_back(ref_vec());
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                send_elem(va[i], vb[i]);
            end
        end
        drain();
        rand_rdy = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
